// File: rtl/vga_frame_monitor_if.sv
// Video input bundle observed by vga_frame_monitor: sync pair plus pixel colour.
// The source drives it through master; the monitor only listens through slave.
interface vga_frame_monitor_if #(
  parameter int RGB_W = 3
);
  logic             hsync;
  logic             vsync;
  logic [RGB_W-1:0] rgb;

  modport master (output hsync, output vsync, output rgb);
  modport slave  (input  hsync, input  vsync, input  rgb);
endinterface

// File: rtl/vga_frame_monitor.sv
// Passive VGA frame monitor: counts samples/lines/frames, flags timing mismatches, checksums pixels.
// Optional macro MON_CSUM_EN adds the per-frame checksum; without it csum reads 0.
module vga_frame_monitor #(
  parameter int RGB_W      = 3,
  parameter int PIX_DIV    = 2,
  parameter int MAX_FRAMES = 200,
  parameter int EXP_LINE   = 320,
  parameter int EXP_LINES  = 262
) (
  input  logic                clk,
  input  logic                reset,
  vga_frame_monitor_if.slave  vga,
  output logic [15:0]         frame_cnt,
  output logic [11:0]         line_len,
  output logic [11:0]         frame_lines,
  output logic [15:0]         csum,
  output logic                frame_done,
  output logic                timing_err,
  output logic                stop
);

  localparam int              DIV_W         = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(PIX_DIV - 1);
  localparam logic [11:0]     EXP_LINE_C    = 12'(EXP_LINE);
  localparam logic [11:0]     EXP_LINES_C   = 12'(EXP_LINES);
  localparam logic [15:0]     MAX_FRAMES_C  = 16'(MAX_FRAMES);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    sat_inc12 = (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  state_t           state_r, state_nx;
  logic [DIV_W-1:0] div_r;
  logic             hs_r, hs_prev_r, vs_r, vs_prev_r;
  logic [11:0]      samp_cnt_r, samp_nx, line_cnt_r, line_nx;
  logic [11:0]      line_len_r, line_len_nx, frame_lines_r, frame_lines_nx;
  logic [15:0]      frame_cnt_r, frame_cnt_nx;
  logic             done_r, done_nx, err_r, err_nx, stop_r, stop_nx;
  logic             strobe_s, hs_fall_s, vs_rise_s, clr_s, close_s;
  logic [11:0]      samp_plus_s, line_plus_s;
  logic [15:0]      frame_inc_s;

  // Edge and strobe decode; the sample is folded in before any line latch uses it
  always_comb begin
    strobe_s    = (div_r == '0);
    hs_fall_s   = hs_prev_r & ~hs_r;
    vs_rise_s   = ~vs_prev_r & vs_r;
    samp_plus_s = (strobe_s && hs_r) ? sat_inc12(samp_cnt_r) : samp_cnt_r;
    line_plus_s = hs_fall_s ? sat_inc12(line_cnt_r) : line_cnt_r;
    frame_inc_s = frame_cnt_r + 16'd1;
  end

  // Next-state and datapath update; a coincident line end is counted into the closing frame
  always_comb begin
    state_nx       = state_r;
    samp_nx        = samp_cnt_r;
    line_nx        = line_cnt_r;
    frame_cnt_nx   = frame_cnt_r;
    line_len_nx    = line_len_r;
    frame_lines_nx = frame_lines_r;
    done_nx        = 1'b0;
    err_nx         = err_r;
    stop_nx        = stop_r;
    clr_s          = 1'b0;
    close_s        = 1'b0;
    case (state_r)
      WAIT_VS: begin
        if (vs_rise_s) begin
          samp_nx  = 12'd0;
          line_nx  = 12'd0;
          clr_s    = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = WAIT_VS;
        end
      end
      RUN: begin
        samp_nx = samp_plus_s;
        if (hs_fall_s) begin
          line_len_nx = samp_plus_s;
          samp_nx     = 12'd0;
          line_nx     = line_plus_s;
          err_nx      = err_r | (samp_plus_s != EXP_LINE_C);
        end else begin
          line_nx = line_cnt_r;
        end
        if (vs_rise_s) begin
          frame_lines_nx = line_plus_s;
          line_nx        = 12'd0;
          close_s        = 1'b1;
          frame_cnt_nx   = frame_inc_s;
          done_nx        = 1'b1;
          err_nx         = err_nx | (line_plus_s != EXP_LINES_C);
          if (frame_inc_s == MAX_FRAMES_C) begin
            state_nx = DONE;
            stop_nx  = 1'b1;
          end else begin
            state_nx = RUN;
          end
        end else begin
          state_nx = RUN;
        end
      end
      DONE: begin
        state_nx = DONE;
      end
      default: begin
        state_nx = WAIT_VS;
      end
    endcase
  end

  // State, divider, sync history and monitor registers; sync history idles high so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= WAIT_VS;
      div_r         <= '0;
      hs_r          <= 1'b1;
      hs_prev_r     <= 1'b1;
      vs_r          <= 1'b1;
      vs_prev_r     <= 1'b1;
      samp_cnt_r    <= 12'd0;
      line_cnt_r    <= 12'd0;
      frame_cnt_r   <= 16'd0;
      line_len_r    <= 12'd0;
      frame_lines_r <= 12'd0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      stop_r        <= 1'b0;
    end else begin
      state_r       <= state_nx;
      div_r         <= (div_r == DIV_LAST) ? '0 : div_r + 1'b1;
      hs_r          <= vga.hsync;
      hs_prev_r     <= hs_r;
      vs_r          <= vga.vsync;
      vs_prev_r     <= vs_r;
      samp_cnt_r    <= samp_nx;
      line_cnt_r    <= line_nx;
      frame_cnt_r   <= frame_cnt_nx;
      line_len_r    <= line_len_nx;
      frame_lines_r <= frame_lines_nx;
      done_r        <= done_nx;
      err_r         <= err_nx;
      stop_r        <= stop_nx;
    end
  end

  assign frame_cnt   = frame_cnt_r;
  assign line_len    = line_len_r;
  assign frame_lines = frame_lines_r;
  assign frame_done  = done_r;
  assign timing_err  = err_r;
  assign stop        = stop_r;

`ifdef MON_CSUM_EN
  logic [RGB_W-1:0] rgb_r;
  logic [15:0]      acc_r, acc_nx, acc_plus_s, csum_r, csum_nx;

  // Visible-pixel accumulator; a sample landing on the closing edge belongs to the closing frame
  always_comb begin
    if (strobe_s && hs_r && vs_r) begin
      acc_plus_s = acc_r + 16'(rgb_r);
    end else begin
      acc_plus_s = acc_r;
    end
    if (clr_s || close_s) begin
      acc_nx = 16'd0;
    end else if (state_r == RUN) begin
      acc_nx = acc_plus_s;
    end else begin
      acc_nx = acc_r;
    end
    if (close_s) begin
      csum_nx = acc_plus_s;
    end else begin
      csum_nx = csum_r;
    end
  end

  // Checksum registers, pixel delayed to line up with the registered syncs
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_r  <= '0;
      acc_r  <= 16'd0;
      csum_r <= 16'd0;
    end else begin
      rgb_r  <= vga.rgb;
      acc_r  <= acc_nx;
      csum_r <= csum_nx;
    end
  end

  assign csum = csum_r;
`else
  assign csum = 16'd0;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor: two instances share one video source, one with MAX_FRAMES=2.
// Line/frame sizes are scaled down (32 samples x 12 lines) so whole frames stay short.
module tb_vga_frame_monitor;
  localparam int PD  = 2;
  localparam int EL  = 32;
  localparam int ELS = 12;
`ifdef MON_CSUM_EN
  localparam int CSUM_NOM = 1152;
  localparam int CSUM_200 = 200;
`else
  localparam int CSUM_NOM = 0;
  localparam int CSUM_200 = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  vga_frame_monitor_if #(.RGB_W(3)) vif ();

  logic [15:0] fc1, cs1, fc2, cs2;
  logic [11:0] ll1, fl1, ll2, fl2;
  logic        fd1, te1, st1, fd2, te2, st2;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt1 = 0;
  int done_cnt2 = 0;
  logic fd1_prev = 1'b0;
  logic fd2_prev = 1'b0;
  logic dbl1 = 1'b0;
  logic dbl2 = 1'b0;
  int done_base;

  vga_frame_monitor #(.RGB_W(3), .PIX_DIV(PD), .MAX_FRAMES(200), .EXP_LINE(EL), .EXP_LINES(ELS)) dut (
    .clk(clk), .reset(reset), .vga(vif.slave),
    .frame_cnt(fc1), .line_len(ll1), .frame_lines(fl1), .csum(cs1),
    .frame_done(fd1), .timing_err(te1), .stop(st1)
  );

  vga_frame_monitor #(.RGB_W(3), .PIX_DIV(PD), .MAX_FRAMES(2), .EXP_LINE(EL), .EXP_LINES(ELS)) dut2 (
    .clk(clk), .reset(reset), .vga(vif.slave),
    .frame_cnt(fc2), .line_len(ll2), .frame_lines(fl2), .csum(cs2),
    .frame_done(fd2), .timing_err(te2), .stop(st2)
  );

  always #5 clk = ~clk;

  // Count frame_done pulses and catch any pulse wider than one cycle
  always @(negedge clk) begin
    if (fd1) done_cnt1 <= done_cnt1 + 1;
    if (fd2) done_cnt2 <= done_cnt2 + 1;
    if (fd1 && fd1_prev) dbl1 <= 1'b1;
    if (fd2 && fd2_prev) dbl2 <= 1'b1;
    fd1_prev <= fd1;
    fd2_prev <= fd2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic line(input int ns);
    vif.hsync = 1'b1;
    tick(2 * ns);
    vif.hsync = 1'b0;
    tick(4);
  endtask

  task automatic vpulse();
    vif.vsync = 1'b0;
    tick(4);
    vif.vsync = 1'b1;
    tick(4);
  endtask

  task automatic frame();
    repeat (ELS) line(EL);
    vpulse();
  endtask

  initial begin
    vif.hsync = 1'b0;
    vif.vsync = 1'b1;
    vif.rgb   = 3'd0;
    reset     = 1'b1;
    tick(3);
    chk("rst_frame_cnt", 32'(fc1), 32'd0);
    chk("rst_line_len", 32'(ll1), 32'd0);
    chk("rst_frame_lines", 32'(fl1), 32'd0);
    chk("rst_csum", 32'(cs1), 32'd0);
    chk("rst_done", 32'(fd1), 32'd0);
    chk("rst_err", 32'(te1), 32'd0);
    chk("rst_stop", 32'(st1), 32'd0);
    reset = 1'b0;
    tick(2);

    // Opening vsync edge only arms the monitor
    vpulse();
    chk("arm_no_frame", 32'(fc1), 32'd0);
    chk("arm_no_done", 32'(done_cnt1), 32'd0);

    vif.rgb = 3'd3;
    frame();
    chk("f1_cnt", 32'(fc1), 32'd1);
    chk("f1_line_len", 32'(ll1), 32'(EL));
    chk("f1_frame_lines", 32'(fl1), 32'(ELS));
    chk("f1_csum", 32'(cs1), 32'(CSUM_NOM));
    chk("f1_stop2", 32'(st2), 32'd0);
    frame();
    chk("f2_cnt", 32'(fc1), 32'd2);
    chk("f2_stop2", 32'(st2), 32'd1);
    chk("f2_cnt2", 32'(fc2), 32'd2);
    frame();
    chk("f3_cnt", 32'(fc1), 32'd3);
    chk("f3_line_len", 32'(ll1), 32'(EL));
    chk("f3_frame_lines", 32'(fl1), 32'(ELS));
    chk("f3_err", 32'(te1), 32'd0);
    chk("f3_done_pulses", 32'(done_cnt1), 32'd3);
    chk("f3_cnt2_held", 32'(fc2), 32'd2);
    chk("f3_stop2", 32'(st2), 32'd1);
    chk("f3_done2", 32'(done_cnt2), 32'd2);

    // Last line ends on the same registered cycle as the vsync rise
    vif.rgb = 3'd0;
    repeat (ELS - 1) line(EL);
    vif.hsync = 1'b1;
    tick(2 * EL - 4);
    vif.vsync = 1'b0;
    tick(4);
    vif.hsync = 1'b0;
    vif.vsync = 1'b1;
    tick(4);
    chk("co_frame_lines", 32'(fl1), 32'(ELS));
    chk("co_line_len", 32'(ll1), 32'(EL));
    chk("co_cnt", 32'(fc1), 32'd4);
    chk("co_err", 32'(te1), 32'd0);
    chk("co_cnt2_held", 32'(fc2), 32'd2);
    chk("co_done2", 32'(done_cnt2), 32'd2);

    // One line one sample short
    vif.hsync = 1'b1;
    tick(2 * (EL - 1));
    vif.hsync = 1'b0;
    tick(1);
    chk("short_err_before", 32'(te1), 32'd0);
    tick(1);
    chk("short_err_rise", 32'(te1), 32'd1);
    chk("short_line_len", 32'(ll1), 32'(EL - 1));
    tick(2);
    repeat (ELS - 1) line(EL);
    vpulse();
    chk("short_frame_lines", 32'(fl1), 32'(ELS));
    chk("short_err_hold", 32'(te1), 32'd1);
    frame();
    chk("after_err_sticky", 32'(te1), 32'd1);
    chk("after_cnt", 32'(fc1), 32'd6);
    chk("single_pulse1", 32'(dbl1), 32'd0);
    chk("single_pulse2", 32'(dbl2), 32'd0);

    // Reset in the middle of a line
    vif.hsync = 1'b1;
    tick(20);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_frame_cnt", 32'(fc1), 32'd0);
    chk("mid_rst_line_len", 32'(ll1), 32'd0);
    chk("mid_rst_frame_lines", 32'(fl1), 32'd0);
    chk("mid_rst_csum", 32'(cs1), 32'd0);
    chk("mid_rst_err", 32'(te1), 32'd0);
    chk("mid_rst_stop2", 32'(st2), 32'd0);
    chk("mid_rst_cnt2", 32'(fc2), 32'd0);
    reset = 1'b0;
    tick(20);
    vif.hsync = 1'b0;
    tick(4);
    done_base = done_cnt1;
    vpulse();
    chk("post_rst_not_frame", 32'(fc1), 32'd0);
    chk("post_rst_no_done", 32'(done_cnt1 - done_base), 32'd0);

    // Checksum pattern: rgb=5, 10 visible samples per line, 4 lines
    vif.rgb = 3'd5;
    repeat (4) line(10);
    vpulse();
    chk("cs_csum", 32'(cs1), 32'(CSUM_200));
    chk("cs_cnt", 32'(fc1), 32'd1);
    chk("cs_frame_lines", 32'(fl1), 32'd4);
    chk("cs_line_len", 32'(ll1), 32'd10);
    chk("cs_err", 32'(te1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_frame_monitor.md
VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

Interface
REQ-001 SHALL have parameter RGB_W, default 3: width of rgb input, legal range 1..8.
REQ-002 SHALL have parameter PIX_DIV, default 2: clk cycles per pixel sample, legal range 1..16.
REQ-003 SHALL have parameter MAX_FRAMES, default 200: frame count at which monitoring stops, legal range 1..65535.
REQ-004 SHALL have parameter EXP_LINE, default 320: expected samples per line with hsync high.
REQ-005 SHALL have parameter EXP_LINES, default 262: expected hsync falling edges per frame.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port hsync, input, 1 bit: horizontal sync, low during sync pulse.
REQ-009 SHALL have port vsync, input, 1 bit: vertical sync, low during sync pulse.
REQ-010 SHALL have port rgb, input, RGB_W bits: pixel colour.
REQ-011 SHALL have port frame_cnt, output, 16 bits: completed frames.
REQ-012 SHALL have port line_len, output, 12 bits: sample count of the last completed line.
REQ-013 SHALL have port frame_lines, output, 12 bits: line count of the last completed frame.
REQ-014 SHALL have port csum, output, 16 bits: checksum of the last completed frame.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse per completed frame.
REQ-016 SHALL have port timing_err, output, 1 bit: sticky timing mismatch flag.
REQ-017 SHALL have port stop, output, 1 bit: high once MAX_FRAMES frames have completed.

Function
REQ-018 SHALL generate a sample strobe every PIX_DIV clk cycles, on the first cycle after reset and each PIX_DIV cycles thereafter; PIX_DIV=1 means strobe every cycle.
REQ-019 SHALL register hsync and vsync once (prev copies); edges SHALL be detected on the registered value versus prev, independent of the strobe.
REQ-020 SHALL implement FSM WAIT_VS -> RUN -> DONE.
REQ-021 In WAIT_VS, SHALL ignore all counting; on the first vsync rising edge, SHALL clear working counters and go to RUN.
REQ-022 In RUN, on each strobe with hsync=1, SHALL increment the sample counter, saturating at 4095.
REQ-023 In RUN, on each strobe with hsync=1 and vsync=1 (visible), SHALL add zero-extended rgb to the working checksum, modulo 2^16.
REQ-024 On an hsync falling edge in RUN, SHALL load line_len with the sample counter, clear it, and increment the line counter (saturating at 4095); if the value differs from EXP_LINE, SHALL set timing_err.
REQ-025 On a vsync rising edge in RUN, SHALL load frame_lines with the line counter and csum with the working checksum; SHALL clear both, increment frame_cnt, and pulse frame_done the next cycle.
REQ-026 If line_lines differs from EXP_LINES at that edge, SHALL set timing_err; the first partial frame before RUN SHALL never be checked.
REQ-027 If an hsync falling edge and a vsync rising edge coincide, SHALL process the line first, so the line counts toward the closing frame.
REQ-028 When frame_cnt reaches MAX_FRAMES, SHALL enter DONE and assert stop; DONE SHALL hold all outputs frozen until reset.
REQ-029 The sample strobe and an hsync edge in the same cycle SHALL count the sample before line_len is latched.

Reset
REQ-030 While reset=1, SHALL set the FSM to WAIT_VS and the strobe divider to 0; all outputs and internal counters SHALL be set to 0.
REQ-031 Reset asserted mid-frame SHALL discard partial line and frame data; timing_err and stop SHALL clear.

Configuration
REQ-032 With macro MON_CSUM_EN defined, SHALL implement the checksum accumulator and csum per REQ-023/025.
REQ-033 Without MON_CSUM_EN, SHALL omit the accumulator and tie csum to 0; all other behaviour SHALL be unchanged.

Verification
REQ-034 Bench SHALL drive the nominal pattern (PIX_DIV=2, 320 samples/line, 262 lines) for 3 frames -> frame_cnt=3, line_len=320, frame_lines=262, timing_err=0, three single-cycle frame_done pulses.
REQ-035 Bench SHALL drive rgb=5 constant, 10 visible samples/line for 4 visible lines, with MON_CSUM_EN -> csum=200; without MON_CSUM_EN -> csum=0.
REQ-036 Bench SHALL shorten one line to 319 samples -> timing_err rises at that hsync falling edge and stays 1 through subsequent correct frames.
REQ-037 Bench SHALL run with MAX_FRAMES=2 for 4 frames -> stop=1 after the 2nd vsync rising edge, frame_cnt held at 2, no further frame_done.
REQ-038 Bench SHALL assert reset mid-line in frame 2 -> all outputs 0 next cycle; the first vsync rising edge afterwards is not counted as a frame.
REQ-039 Bench SHALL coincide an hsync falling edge with a vsync rising edge -> frame_lines includes that line (262, not 261).
